// File: rtl/pe_conv_pkg.sv
// Shared pe_conv definitions: window geometry and buffer FSM states.
// Used by both the input buffer and the output MAC buffer.
package pe_conv_pkg;

    localparam int unsigned PIXELS_PER_WINDOW = 9;
    localparam int unsigned PIXEL_IDX_W       = 4;

    typedef enum logic {
        StFill,
        StFull
    } buf_state_e;

endpackage

// File: rtl/pe_conv_mac_buffer_out_conv1_if.sv
// Sample-in / packed-window-out handshake bundle for the conv1 output buffer.
interface pe_conv_mac_buffer_out_conv1_if #(
    parameter int unsigned pDATA_WIDTH  = 8,
    parameter int unsigned pKERNEL_SIZE = 3
);
    import pe_conv_pkg::*;

    logic                                              en;
    logic [pDATA_WIDTH-1:0]                            data_in;
    logic                                              ready;
    logic [pDATA_WIDTH*pKERNEL_SIZE*pKERNEL_SIZE-1:0]  data_out;
    logic [PIXEL_IDX_W-1:0]                            pixel;
    logic                                              valid;
    logic                                              overflow;

    modport master (
        output en, data_in, ready,
        input  data_out, pixel, valid, overflow
    );

    modport slave (
        input  en, data_in, ready,
        output data_out, pixel, valid, overflow
    );

endinterface

// File: rtl/pe_conv_mac_buffer_out_ctrl.sv
// Fill/full FSM, pixel counter and sticky overflow; emits one-hot slot write enables.
module pe_conv_mac_buffer_out_ctrl
    import pe_conv_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         ready_i,
    output logic [PIXEL_IDX_W-1:0]       pixel_o,
    output logic                         valid_o,
    output logic                         overflow_o,
    output logic [PIXELS_PER_WINDOW-1:0] slot_we_o
);

    localparam logic [PIXEL_IDX_W-1:0] LastIdx = PIXEL_IDX_W'(PIXELS_PER_WINDOW - 1);

    buf_state_e             state_q, state_d;
    logic [PIXEL_IDX_W-1:0] pixel_q, pixel_d;
    logic                   overflow_q, overflow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFill;
            pixel_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pixel_q    <= pixel_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pixel_d    = pixel_q;
        overflow_d = overflow_q;
        slot_we_o  = '0;
        case (state_q)
            StFill: begin
                if (en_i) begin
                    for (int i = 0; i < int'(PIXELS_PER_WINDOW); i++) begin
                        if (pixel_q == PIXEL_IDX_W'(i)) slot_we_o[i] = 1'b1;
                    end
                    if (pixel_q == LastIdx) begin
                        pixel_d = '0;
                        state_d = StFull;
                    end else begin
                        pixel_d = pixel_q + PIXEL_IDX_W'(1);
                    end
                end
            end
            StFull: begin
                if (ready_i) begin
                    // A sample arriving on the handshake edge starts the next window.
                    state_d = StFill;
                    if (en_i) begin
                        slot_we_o[0] = 1'b1;
                        pixel_d      = PIXEL_IDX_W'(1);
                    end else begin
                        pixel_d      = '0;
                    end
                end else if (en_i) begin
                    overflow_d = 1'b1;
                end
            end
        endcase
    end

    assign pixel_o    = pixel_q;
    assign valid_o    = (state_q == StFull);
    assign overflow_o = overflow_q;

endmodule

// File: rtl/pe_conv_mac_buffer_out_conv1.sv
// conv1 output window buffer: packs nine samples into one 72-bit window with ready/valid.
module pe_conv_mac_buffer_out_conv1
    import pe_conv_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH  = 8,
    parameter int unsigned pKERNEL_SIZE = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    pe_conv_mac_buffer_out_conv1_if.slave   bus
);

    localparam int unsigned NumPix = pKERNEL_SIZE * pKERNEL_SIZE;

    logic [PIXELS_PER_WINDOW-1:0] slot_we;
    logic [pDATA_WIDTH-1:0]       slot_q [NumPix];

    pe_conv_mac_buffer_out_ctrl u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .en_i       (bus.en),
        .ready_i    (bus.ready),
        .pixel_o    (bus.pixel),
        .valid_o    (bus.valid),
        .overflow_o (bus.overflow),
        .slot_we_o  (slot_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NumPix); i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NumPix); i++) begin
                if (slot_we[i]) slot_q[i] <= bus.data_in;
            end
        end
    end

    always_comb begin
        bus.data_out = '0;
        for (int i = 0; i < int'(NumPix); i++) begin
            bus.data_out[i*pDATA_WIDTH +: pDATA_WIDTH] = slot_q[i];
        end
    end

endmodule

// File: tb/tb_pe_conv_mac_buffer_out_conv1.sv
// Randomized and directed bench for the conv1 output window buffer against a queue-based model.
module tb_pe_conv_mac_buffer_out_conv1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pe_conv_mac_buffer_out_conv1_if #(.pDATA_WIDTH(8), .pKERNEL_SIZE(3)) bus ();

    pe_conv_mac_buffer_out_conv1 #(.pDATA_WIDTH(8), .pKERNEL_SIZE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: samples collected so far, plus the held window while full.
    logic [7:0]  m_win[$];
    bit          m_full;
    bit          m_ovf;
    logic [71:0] m_out;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input logic [7:0] d, input bit rd);
        if (r) begin
            m_win.delete();
            m_full = 1'b0;
            m_ovf  = 1'b0;
            m_out  = '0;
        end else if (m_full) begin
            if (rd) begin
                m_full = 1'b0;
                if (e) m_win.push_back(d);
            end else if (e) begin
                m_ovf = 1'b1;
            end
        end else if (e) begin
            m_win.push_back(d);
            if (m_win.size() == 9) begin
                for (int k = 0; k < 9; k++) m_out[8*k +: 8] = m_win[k];
                m_win.delete();
                m_full = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit e, input logic [7:0] d, input bit rd);
        rst         = r;
        bus.en      = e;
        bus.data_in = d;
        bus.ready   = rd;
        @(posedge clk);
        model_step(r, e, d, rd);
        #1;
        check_eq("valid", {71'd0, bus.valid}, {71'd0, m_full});
        check_eq("pixel", {68'd0, bus.pixel}, 72'(m_win.size()));
        check_eq("overflow", {71'd0, bus.overflow}, {71'd0, m_ovf});
        if (m_full) check_eq("data_out", bus.data_out, m_out);
        if (r) check_eq("data_out_rst", bus.data_out, 72'd0);
    endtask

    task automatic send9(input logic [7:0] base, input int max_gap);
        for (int i = 0; i < 9; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 8'($urandom), 1'b0);
            cycle(1'b0, 1'b1, base + 8'(i), 1'b0);
        end
    endtask

    logic [71:0] snap;

    initial begin
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_out  = '0;
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'hFF, 1'b1);

        // Basic fill, valid one edge after the 9th sample.
        send9(8'h01, 0);
        check_eq("win_01_09", bus.data_out, 72'h090807060504030201);

        // Hold under backpressure, then release.
        snap = bus.data_out;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check_eq("hold_stable", bus.data_out, snap);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Handshake and new sample on the same edge.
        send9(8'h21, 0);
        cycle(1'b0, 1'b1, 8'hAA, 1'b1);
        check_eq("hs_pixel", {68'd0, bus.pixel}, 72'd1);
        for (int i = 1; i < 9; i++) cycle(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
        check_eq("slot0_aa", {64'd0, bus.data_out[7:0]}, 72'hAA);

        // Dropped sample sets sticky overflow.
        snap = bus.data_out;
        cycle(1'b0, 1'b1, 8'h55, 1'b0);
        check_eq("ovf_data", bus.data_out, snap);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        send9(8'h60, 0);
        check_eq("ovf_sticky", {71'd0, bus.overflow}, 72'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset in the middle of a partial window.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hE0 + 8'(i), 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        send9(8'h10, 0);
        check_eq("win_10_18", bus.data_out, 72'h181716151413121110);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Random en gaps.
        send9(8'h01, 3);
        check_eq("win_gaps", bus.data_out, 72'h090807060504030201);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Fully random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(63, 0) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
